unpadding_strip: RTL and testbench
==================================

UNPADDING_STRIP -- requirements
Module: unpadding_strip

Interface
REQ-001 SHALL have parameter D, default 220: inner (unpadded) frame width and height in pixels.
REQ-002 SHALL have parameter P, default 1: border width stripped on each side; legal range 1..8.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: pixel width in bits.
REQ-004 SHALL have port clk  input  1: clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1: reset, asynchronous, active-high.
REQ-006 SHALL have port in_valid  input  1: pxl_in carries a pixel this cycle.
REQ-007 SHALL have port in_sof  input  1: qualified by in_valid; marks the first pixel (row 0, col 0) of a padded frame.
REQ-008 SHALL have port pxl_in  input  DATA_WIDTH: padded-frame pixel, raster order, (D+2P)x(D+2P) per frame.
REQ-009 SHALL have port pxl_out  output  DATA_WIDTH: retained interior pixel.
REQ-010 SHALL have port out_valid  output  1: pxl_out is valid this cycle.
REQ-011 SHALL have port out_last  output  1: high with out_valid on the final interior pixel of a frame.
REQ-012 SHALL have port frame_done  output  1: one-cycle pulse after the last padded input pixel is consumed.
REQ-013 SHALL have port frame_err  output  1: one-cycle pulse on a protocol error (REQ-021).

Function
REQ-014 SHALL implement states IDLE and RUN; IDLE after reset.
REQ-015 In IDLE, SHALL ignore in_valid without in_sof: no output, counters held at 0.
REQ-016 In IDLE, in_valid && in_sof SHALL treat that pixel as (row 0, col 0), advance col to 1, and enter RUN.
REQ-017 In RUN, each in_valid cycle SHALL advance col; at col = D+2P-1, col wraps to 0 and row increments; in_valid low holds all counters and state.
REQ-018 A pixel at (row, col) SHALL be retained iff P <= row <= D+P-1 and P <= col <= D+P-1; retained pixels appear on pxl_out with out_valid high exactly 1 cycle after acceptance (registered output).
REQ-019 out_last SHALL be high only with out_valid for pixel (D+P-1, D+P-1).
REQ-020 On acceptance of pixel (D+2P-1, D+2P-1), counters SHALL reset to 0, state returns to IDLE, and frame_done pulses 1 cycle later.
REQ-021 in_valid && in_sof in RUN at any position other than (0,0) SHALL pulse frame_err 1 cycle later, restart the frame treating that pixel as (0,0), and stay in RUN; no frame_done for the aborted frame.
REQ-022 Non-retained or non-valid cycles SHALL drive out_valid = 0 and out_last = 0; pxl_out holds its last value.
REQ-023 Counters SHALL be sized ceil(log2(D+2P+1)) bits; no arithmetic overflow for legal parameters.
REQ-024 Back-to-back frames (in_sof on the cycle after the previous frame's last pixel) SHALL be accepted with no bubble.
REQ-025 Exactly D*D out_valid pulses SHALL occur per completed frame.

Reset
REQ-026 While reset is high: state IDLE, row = col = 0, pxl_out = 0, out_valid = 0, out_last = 0, frame_done = 0, frame_err = 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; no outputs pulse on reset release; next frame requires in_sof.

Verification (D=4, P=1, 6x6 input, pxl_in = index 0..35)
REQ-028 Continuous frame with in_sof on index 0 -> out_valid exactly 16 cycles, pxl_out = 7,8,9,10,13,14,15,16,19,20,21,22,25,26,27,28; out_last with 28; frame_done 1 cycle after index 35 accepted.
REQ-029 Same frame with in_valid low every other cycle -> identical output sequence, each output 1 cycle after its input, no extra out_valid.
REQ-030 Pixels streamed before any in_sof -> no out_valid; frame starting with in_sof then decodes as REQ-028.
REQ-031 in_sof reasserted at index 20 -> frame_err pulse; that pixel treated as (0,0); next 16 retained outputs follow REQ-028 positions relative to restart.
REQ-032 Two frames back-to-back -> 32 outputs, two out_last, two frame_done pulses, no gap.
REQ-033 reset asserted at index 15 then released, new frame with in_sof -> all outputs 0 during reset, subsequent frame matches REQ-028.

Source files
------------

// File: rtl/unpadding_strip.sv
// Strips a P-pixel border from a raster-ordered (D+2P)x(D+2P) padded frame,
// forwarding only the DxD interior pixels with registered handshake outputs.
module unpadding_strip #(
  parameter int D          = 220,
  parameter int P          = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sof,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int W  = D + 2 * P;
  localparam int CW = $clog2(W + 1);

  localparam logic [CW-1:0] LO   = CW'(P);
  localparam logic [CW-1:0] HI   = CW'(D + P - 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [DATA_WIDTH-1:0]   pxl_q, pxl_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept_s;
  logic                    restart_s;
  logic                    keep_s;
  logic                    end_s;
  logic [CW-1:0]           row_s;
  logic [CW-1:0]           col_s;

  // An in_sof pixel always counts as (0,0), whether starting or restarting a frame.
  always_comb begin
    accept_s  = in_valid && (in_sof || (state_q == RUN));
    restart_s = in_valid && in_sof;
    if (restart_s) begin
      row_s = ZERO;
      col_s = ZERO;
    end else begin
      row_s = row_q;
      col_s = col_q;
    end
    end_s  = accept_s && (row_s == LAST) && (col_s == LAST);
    keep_s = accept_s && (row_s >= LO) && (row_s <= HI) && (col_s >= LO) && (col_s <= HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= ZERO;
      col_q   <= ZERO;
      pxl_q   <= {DATA_WIDTH{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pxl_q   <= pxl_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (accept_s) begin
      if (end_s) begin
        state_d = IDLE;
        row_d   = ZERO;
        col_d   = ZERO;
      end else if (col_s == LAST) begin
        state_d = RUN;
        row_d   = row_s + ONE;
        col_d   = ZERO;
      end else begin
        state_d = RUN;
        row_d   = row_s;
        col_d   = col_s + ONE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Output next-state; pxl_out keeps its last retained value between pulses.
  always_comb begin
    valid_d = keep_s;
    last_d  = keep_s && (row_s == HI) && (col_s == HI);
    done_d  = end_s;
    err_d   = (state_q == RUN) && restart_s && ((row_q != ZERO) || (col_q != ZERO));
    if (keep_s) begin
      pxl_d = pxl_in;
    end else begin
      pxl_d = pxl_q;
    end
  end

  assign pxl_out    = pxl_q;
  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_unpadding_strip.sv
// Self-checking bench for unpadding_strip (D=4, P=1): directed frames plus
// randomized traffic compared against a frame-index reference model.
module tb_unpadding_strip;

  localparam int D  = 4;
  localparam int P  = 1;
  localparam int DW = 32;
  localparam int W  = D + 2 * P;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] pxl_in;
  logic [DW-1:0] pxl_out;
  logic          out_valid;
  logic          out_last;
  logic          frame_done;
  logic          frame_err;

  unpadding_strip #(.D(D), .P(P), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .pxl_in     (pxl_in),
    .pxl_out    (pxl_out),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: position is a flat index into the padded frame.
  bit            in_frame;
  int            idx;
  logic [DW-1:0] e_pxl;
  bit            e_valid, e_last, e_done, e_err;

  int            n_valid, n_last, n_done, n_err;
  logic [DW-1:0] obs_q[$];
  int            exp_pos[16] = '{7, 8, 9, 10, 13, 14, 15, 16, 19, 20, 21, 22, 25, 26, 27, 28};

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_frame = 1'b0;
    idx      = 0;
    e_pxl    = '0;
    e_valid  = 1'b0;
    e_last   = 1'b0;
    e_done   = 1'b0;
    e_err    = 1'b0;
  endtask

  task automatic model_edge();
    int pos;
    bit acc;
    int r, c;
    acc     = 1'b0;
    pos     = 0;
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    if (in_valid) begin
      if (in_sof) begin
        if (in_frame) e_err = 1'b1;
        pos = 0;
        acc = 1'b1;
      end else if (in_frame) begin
        pos = idx;
        acc = 1'b1;
      end
    end
    if (acc) begin
      r = pos / W;
      c = pos % W;
      if (r >= P && r < D + P && c >= P && c < D + P) begin
        e_valid = 1'b1;
        e_pxl   = pxl_in;
        e_last  = (r == D + P - 1) && (c == D + P - 1);
      end
      idx      = pos + 1;
      in_frame = 1'b1;
      if (idx == W * W) begin
        idx      = 0;
        in_frame = 1'b0;
        e_done   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    chk("pxl_out", pxl_out, e_pxl);
    chk("out_valid", DW'(out_valid), DW'(e_valid));
    chk("out_last", DW'(out_last), DW'(e_last));
    chk("frame_done", DW'(frame_done), DW'(e_done));
    chk("frame_err", DW'(frame_err), DW'(e_err));
    if (out_valid) begin
      n_valid++;
      obs_q.push_back(pxl_out);
    end
    if (out_last)   n_last++;
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  endtask

  task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    pxl_in   = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (cycles) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int k = 0; k < W * W; k++) begin
      if (gaps) step(1'b0, 1'b0, DW'(999));
      step(1'b1, k == 0, DW'(base + k));
    end
  endtask

  task automatic check_obs(input string tag, input int b0, input int b1, input int nframes);
    chk({tag, "_count"}, DW'(obs_q.size()), DW'(16 * nframes));
    for (int i = 0; i < obs_q.size() && i < 16 * nframes; i++)
      chk({tag, "_pixel"}, obs_q[i], DW'(((i < 16) ? b0 : b1) + exp_pos[i % 16]));
    obs_q.delete();
  endtask

  initial begin
    int lv, dn, er;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    pxl_in   = '0;
    n_valid = 0; n_last = 0; n_done = 0; n_err = 0;
    model_reset();
    do_reset(2);

    // Pixels before any in_sof are ignored; then a clean continuous frame.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, DW'(500 + k));
    chk("pre_sof_quiet", DW'(obs_q.size()), DW'(0));
    lv = n_last; dn = n_done;
    send_frame(0, 1'b0);
    step(1'b0, 1'b0, '0);
    check_obs("cont", 0, 0, 1);
    chk("cont_last", DW'(n_last - lv), DW'(1));
    chk("cont_done", DW'(n_done - dn), DW'(1));

    // Same frame with in_valid low every other cycle.
    send_frame(0, 1'b1);
    step(1'b0, 1'b0, '0);
    check_obs("gaps", 0, 0, 1);

    // Restart at index 20.
    er = n_err; dn = n_done;
    for (int k = 0; k < 20; k++) step(1'b1, k == 0, DW'(k));
    obs_q.delete();
    send_frame(20, 1'b0);
    step(1'b0, 1'b0, '0);
    check_obs("restart", 20, 20, 1);
    chk("restart_err", DW'(n_err - er), DW'(1));
    chk("restart_done", DW'(n_done - dn), DW'(1));

    // Back-to-back frames.
    lv = n_last; dn = n_done;
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    step(1'b0, 1'b0, '0);
    check_obs("b2b", 0, 100, 2);
    chk("b2b_last", DW'(n_last - lv), DW'(2));
    chk("b2b_done", DW'(n_done - dn), DW'(2));

    // Reset mid-frame at index 15, then a fresh frame.
    for (int k = 0; k < 15; k++) step(1'b1, k == 0, DW'(k));
    do_reset(2);
    obs_q.delete();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, DW'(700 + k));
    send_frame(0, 1'b0);
    step(1'b0, 1'b0, '0);
    check_obs("post_reset", 0, 0, 1);

    // Randomized traffic: gaps, stray in_sof, random data.
    for (int f = 0; f < 25; f++) begin
      for (int g = 0; g < $urandom_range(0, 3); g++)
        step(1'($urandom_range(0, 1)), 1'b0, $urandom);
      for (int k = 0; k < W * W; k++) begin
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), $urandom);
        step(1'b1, (k == 0) || ($urandom_range(0, 39) == 0), $urandom);
      end
    end
    step(1'b0, 1'b0, '0);
    obs_q.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
